// File: rtl/uart_param.sv
// UART with TX/RX FIFOs, runtime parity/stop selection and 8-bit register bus.
// Single clock domain; rx_bit is synchronised before use.
module uart_param_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module uart_param #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 38
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tx_bit,
    input  logic       rx_bit,
    input  logic [2:0] wb_addr,
    input  logic [7:0] wb_data_in,
    output logic [7:0] wb_data_out,
    input  logic       wb_we,
    input  logic       wb_stb,
    output logic       wb_ack,
    output logic       irq
);
    localparam int SW = $clog2(2 * OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] OS_END   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] OS2_END  = SW'(2 * OVERSAMPLE - 1);
    localparam logic [SW-1:0] HALF_END = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] LAST     = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_state_t;
    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK
    } rx_state_t;

    logic acc, wr, rd;
    logic tx_push, tx_pop, rx_push, rx_pop, st_rd;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_busy;
    logic [DATA_BITS-1:0] tx_dout, rx_dout;
    logic [DIV_WIDTH-1:0] div_r, tcnt;
    logic [15:0] div_pad;
    logic [4:0] ctrl;
    logic [7:0] rdata, status;
    logic tick;
    logic ovr, frm, par;

    assign acc     = wb_stb && !wb_ack;
    assign wr      = acc && wb_we;
    assign rd      = acc && !wb_we;
    assign tx_push = wr && wb_addr == 3'd0;
    assign rx_pop  = rd && wb_addr == 3'd1;
    assign st_rd   = rd && wb_addr == 3'd5;
    assign div_pad = 16'(div_r);
    assign tick    = tcnt == div_r;
    assign status  = {tx_busy, par, frm, ovr,
                      rx_empty, rx_full, tx_empty, tx_full};

    uart_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .din(wb_data_in[DATA_BITS-1:0]), .dout(tx_dout),
        .full(tx_full), .empty(tx_empty)
    );

    always_comb begin
        rdata = '0;
        unique case (wb_addr)
            3'd1:    rdata = rx_empty ? '0 : 8'(rx_dout);
            3'd2:    rdata = div_pad[7:0];
            3'd3:    rdata = div_pad[15:8];
            3'd4:    rdata = {3'b000, ctrl};
            3'd5:    rdata = status;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack      <= 1'b0;
            wb_data_out <= '0;
            div_r       <= DIV_WIDTH'(DEFAULT_DIV);
            ctrl        <= '0;
            irq         <= 1'b0;
        end else begin
            wb_ack <= acc;
            if (acc) wb_data_out <= rdata;
            if (wr) begin
                unique case (wb_addr)
                    3'd2: div_r <= DIV_WIDTH'({div_pad[15:8], wb_data_in});
                    3'd3: div_r <= DIV_WIDTH'({wb_data_in, div_pad[7:0]});
                    3'd4: ctrl  <= wb_data_in[4:0];
                    default: ;
                endcase
            end
            irq <= (ctrl[3] && !rx_empty) ||
                   (ctrl[4] && tx_empty && !tx_busy);
        end
    end

    // Any divider write restarts the tick phase.
    always_ff @(posedge clk) begin
        if (reset || tick || (wr && (wb_addr == 3'd2 || wb_addr == 3'd3)))
            tcnt <= '0;
        else
            tcnt <= tcnt + DIV_WIDTH'(1);
    end

    tx_state_t ts;
    logic [SW-1:0] tsc;
    logic [IW-1:0] tidx;
    logic [DATA_BITS-1:0] tsh;
    logic tpar, tpen, t2s;

    assign tx_busy = ts != T_IDLE;
    assign tx_pop  = tick && ts == T_IDLE && !tx_empty;

    // Frame format is latched at pop so CTRL edits never split a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= T_IDLE; tx_bit <= 1'b1; tsc <= '0; tidx <= '0;
            tsh <= '0; tpar <= 1'b0; tpen <= 1'b0; t2s <= 1'b0;
        end else if (tick) begin
            tsc <= tsc + SW'(1);
            case (ts)
                T_IDLE: begin
                    tsc <= '0;
                    if (!tx_empty) begin
                        ts <= T_START; tx_bit <= 1'b0; tsh <= tx_dout;
                        tpar <= ^tx_dout ^ ctrl[1];
                        tpen <= ctrl[0]; t2s <= ctrl[2];
                    end
                end
                T_START: if (tsc == OS_END) begin
                    ts <= T_DATA; tx_bit <= tsh[0]; tsc <= '0; tidx <= '0;
                end
                T_DATA: if (tsc == OS_END) begin
                    tsc <= '0;
                    if (tidx == LAST) begin
                        ts <= tpen ? T_PAR : T_STOP;
                        tx_bit <= tpen ? tpar : 1'b1;
                    end else begin
                        tidx <= tidx + IW'(1);
                        tsh <= tsh >> 1;
                        tx_bit <= tsh[1];
                    end
                end
                T_PAR: if (tsc == OS_END) begin
                    ts <= T_STOP; tx_bit <= 1'b1; tsc <= '0;
                end
                T_STOP: if (tsc == (t2s ? OS2_END : OS_END)) begin
                    ts <= T_IDLE; tsc <= '0;
                end
                default: ts <= T_IDLE;
            endcase
        end
    end

    rx_state_t rs;
    logic [1:0] rsync;
    logic rx_s;
    logic [SW-1:0] rsc;
    logic [IW-1:0] ridx;
    logic [DATA_BITS-1:0] rsh;
    logic rpen, rodd, rbad;

    assign rx_s    = rsync[1];
    assign rx_push = tick && rs == R_STOP && rsc == OS_END;

    uart_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
        .din(rsh), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsync <= 2'b11; rs <= R_IDLE; rsc <= '0; ridx <= '0;
            rsh <= '0; rpen <= 1'b0; rodd <= 1'b0; rbad <= 1'b0;
            ovr <= 1'b0; frm <= 1'b0; par <= 1'b0;
        end else begin
            rsync <= {rsync[0], rx_bit};
            if (st_rd) begin
                ovr <= 1'b0; frm <= 1'b0; par <= 1'b0;
            end
            case (rs)
                R_IDLE: if (!rx_s) begin
                    rs <= R_START; rsc <= '0;
                end
                R_START: if (tick) begin
                    rsc <= rsc + SW'(1);
                    if (rsc == HALF_END) begin
                        rs <= rx_s ? R_IDLE : R_DATA;
                        rsc <= '0; ridx <= '0; rbad <= 1'b0;
                        rpen <= ctrl[0]; rodd <= ctrl[1];
                    end
                end
                R_DATA: if (tick) begin
                    rsc <= rsc + SW'(1);
                    if (rsc == OS_END) begin
                        rsc <= '0;
                        rsh <= {rx_s, rsh[DATA_BITS-1:1]};
                        ridx <= ridx + IW'(1);
                        if (ridx == LAST) rs <= rpen ? R_PAR : R_STOP;
                    end
                end
                R_PAR: if (tick) begin
                    rsc <= rsc + SW'(1);
                    if (rsc == OS_END) begin
                        rsc <= '0; rs <= R_STOP;
                        rbad <= rx_s != (^rsh ^ rodd);
                    end
                end
                R_STOP: if (tick) begin
                    rsc <= rsc + SW'(1);
                    if (rsc == OS_END) begin
                        rsc <= '0;
                        rs <= rx_s ? R_IDLE : R_BRK;
                        if (!rx_s) frm <= 1'b1;
                        if (rbad) par <= 1'b1;
                        if (rx_full) ovr <= 1'b1;
                    end
                end
                R_BRK: if (rx_s) rs <= R_IDLE;
                default: rs <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: register vectors, line-level TX decode and RX frame drive.
// Frames are predicted from byte + CTRL and compared to what the line carries.
module tb_uart_param;
    localparam int BT = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_bit, rx_bit, wb_we, wb_stb, wb_ack, irq;
    logic [2:0] wb_addr;
    logic [7:0] wb_data_in, wb_data_out;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;

    int total = 0;
    int passed = 0;
    int mon_len = 10;
    logic [11:0] tx_obs[$];

    assign rx_bit = loop_en ? tx_bit : rx_drv;

    always #5 clk = ~clk;

    uart_param dut (
        .clk(clk), .reset(reset), .tx_bit(tx_bit), .rx_bit(rx_bit),
        .wb_addr(wb_addr), .wb_data_in(wb_data_in),
        .wb_data_out(wb_data_out), .wb_we(wb_we), .wb_stb(wb_stb),
        .wb_ack(wb_ack), .irq(irq)
    );

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic bus(input logic we, input logic [2:0] a,
                       input logic [7:0] d, output logic [7:0] q);
        int n;
        @(negedge clk);
        wb_we = we; wb_addr = a; wb_data_in = d; wb_stb = 1'b1;
        n = 0;
        while (!wb_ack && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!wb_ack) begin
            total++;
            $display("FAIL bus_ack: no ack after %0d cycles, want 1", n);
        end
        q = wb_data_out;
        wb_stb = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a,
                          input logic [7:0] exp);
        logic [7:0] q;
        bus(1'b0, a, 8'h00, q);
        chk(nm, q, exp);
    endtask

    function automatic logic [11:0] exp_frame(input logic [7:0] d,
                                              input logic [4:0] c);
        logic [11:0] f;
        int n;
        f = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            f[n] = d[i];
            n++;
        end
        if (c[0]) begin
            f[n] = (^d) ^ c[1];
            n++;
        end
        f[n] = 1'b1;
        return f;
    endfunction

    task automatic rx_frame(input logic [7:0] d, input logic pen,
                            input logic odd, input logic flip,
                            input logic bad);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BT) @(negedge clk);
        end
        if (pen) begin
            rx_drv = (^d) ^ odd ^ flip;
            repeat (BT) @(negedge clk);
        end
        rx_drv = !bad;
        repeat (BT) @(negedge clk);
        rx_drv = 1'b1;
        repeat (BT) @(negedge clk);
    endtask

    task automatic wait_obs(input int n, input int lim);
        int c;
        c = 0;
        while (tx_obs.size() < n && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk("tx_frame_count", tx_obs.size(), n);
    endtask

    task automatic wait_tx_low(output logic ok);
        int c;
        c = 0;
        while (tx_bit !== 1'b0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        ok = tx_bit === 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL tx_start: tx_bit stayed %0b, want 0", tx_bit);
        end
    endtask

    initial begin : mon
        logic [11:0] f;
        forever begin
            @(negedge clk);
            if (!reset && tx_bit === 1'b0) begin
                f = '0;
                repeat (BT / 2 - 1) @(negedge clk);
                f[0] = tx_bit;
                for (int i = 1; i < mon_len; i++) begin
                    repeat (BT) @(negedge clk);
                    f[i] = tx_bit;
                end
                tx_obs.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt[14];
        logic [7:0] q, b;
        logic [7:0] rxq[$];
        logic [7:0] txq[$];
        logic [7:0] lb[3];
        logic ok, ovr_exp;
        int w;

        vt[0]  = '{1'b0, 3'd5, 8'h00, 8'h0A};
        vt[1]  = '{1'b0, 3'd2, 8'h00, 8'd38};
        vt[2]  = '{1'b0, 3'd3, 8'h00, 8'h00};
        vt[3]  = '{1'b0, 3'd4, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 3'd1, 8'h00, 8'h00};
        vt[5]  = '{1'b0, 3'd6, 8'h00, 8'h00};
        vt[6]  = '{1'b1, 3'd3, 8'hFF, 8'h00};
        vt[7]  = '{1'b0, 3'd3, 8'h00, 8'hFF};
        vt[8]  = '{1'b1, 3'd3, 8'h00, 8'h00};
        vt[9]  = '{1'b1, 3'd2, 8'h03, 8'h00};
        vt[10] = '{1'b0, 3'd2, 8'h00, 8'h03};
        vt[11] = '{1'b1, 3'd4, 8'hFF, 8'h00};
        vt[12] = '{1'b0, 3'd4, 8'h00, 8'h1F};
        vt[13] = '{1'b1, 3'd7, 8'h55, 8'h00};

        wb_we = 1'b0; wb_stb = 1'b0; wb_addr = '0; wb_data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx_bit", tx_bit, 1'b1);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ack", wb_ack, 1'b0);
        chk("rst_dout", wb_data_out, 8'h00);

        for (int i = 0; i < 14; i++) begin
            bus(vt[i].we, vt[i].addr, vt[i].data, q);
            if (!vt[i].we) chk($sformatf("vec%0d", i), q, vt[i].exp);
        end
        @(negedge clk);
        chk("ack_one_cycle", wb_ack, 1'b0);
        rd_chk("reg7_reads0", 3'd7, 8'h00);
        wr(3'd4, 8'h00);

        tx_obs.delete();
        wr(3'd0, 8'hA5);
        wait_tx_low(ok);
        if (ok) begin
            w = 0;
            while (tx_bit === 1'b0 && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("start_width", w, BT);
        end
        rd_chk("status_busy", 3'd5, 8'h8A);
        wait_obs(1, 2000);
        if (tx_obs.size() >= 1)
            chk("frame_A5", tx_obs[0], exp_frame(8'hA5, 5'h00));
        repeat (200) @(negedge clk);
        rd_chk("status_idle", 3'd5, 8'h0A);

        wr(3'd4, 8'h03);
        loop_en = 1'b1;
        mon_len = 11;
        tx_obs.delete();
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;
        for (int i = 0; i < 3; i++) wr(3'd0, lb[i]);
        wait_obs(3, 4000);
        for (int i = 0; i < 3 && i < tx_obs.size(); i++) begin
            chk($sformatf("lb_frame%0d", i), tx_obs[i],
                exp_frame(lb[i], 5'h03));
            chk($sformatf("lb_par%0d", i), tx_obs[i][9], 1'b1);
        end
        repeat (200) @(negedge clk);
        for (int i = 0; i < 3; i++)
            rd_chk($sformatf("lb_rx%0d", i), 3'd1, lb[i]);
        rd_chk("lb_status", 3'd5, 8'h0A);
        loop_en = 1'b0;
        mon_len = 10;
        wr(3'd4, 8'h00);

        rx_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        rd_chk("frame_err_set", 3'd5, 8'h22);
        rd_chk("frame_err_data", 3'd1, 8'h55);
        rd_chk("frame_err_clr", 3'd5, 8'h0A);
        wr(3'd4, 8'h01);
        rx_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        rd_chk("par_err_set", 3'd5, 8'h42);
        rd_chk("par_err_data", 3'd1, 8'h55);
        rd_chk("par_err_clr", 3'd5, 8'h0A);
        wr(3'd4, 8'h00);

        ovr_exp = 1'b0;
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom);
            rx_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
            if (rxq.size() < 16) rxq.push_back(b);
            else ovr_exp = 1'b1;
        end
        rd_chk("ovr_status", 3'd5,
               {3'b000, ovr_exp, rxq.size() == 0,
                rxq.size() == 16, 2'b10});
        for (int k = 0; k < 16; k++)
            rd_chk($sformatf("ovr_rx%0d", k), 3'd1, rxq[k]);
        rd_chk("ovr_drained", 3'd5, 8'h0A);

        wr(3'd3, 8'hFF);
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom);
            wr(3'd0, b);
            if (txq.size() < 16) txq.push_back(b);
        end
        rd_chk("tx_full", 3'd5, 8'h09);
        tx_obs.delete();
        wr(3'd3, 8'h00);
        wait_obs(16, 16 * 800);
        for (int k = 0; k < 16 && k < tx_obs.size(); k++)
            chk($sformatf("tx_rand%0d", k), tx_obs[k],
                exp_frame(txq[k], 5'h00));
        repeat (1500) @(negedge clk);
        chk("tx_17th_dropped", tx_obs.size(), 16);
        rd_chk("tx_drained", 3'd5, 8'h0A);

        wr(3'd0, 8'h00);
        wait_tx_low(ok);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midframe_reset_tx", tx_bit, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midframe_reset_dout", wb_data_out, 8'h00);
        rd_chk("midframe_reset_status", 3'd5, 8'h0A);
        rd_chk("midframe_reset_div", 3'd2, 8'd38);
        repeat (800) @(negedge clk);
        chk("no_tx_after_reset", tx_bit, 1'b1);
        tx_obs.delete();
        wr(3'd2, 8'h03);

        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        rd_chk("glitch_no_push", 3'd5, 8'h0A);

        wr(3'd4, 8'h08);
        repeat (2) @(negedge clk);
        chk("irq_rx_idle", irq, 1'b0);
        rx_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("irq_rx_set", irq, 1'b1);
        rd_chk("irq_rx_data", 3'd1, 8'hC3);
        repeat (2) @(negedge clk);
        chk("irq_rx_clr", irq, 1'b0);
        wr(3'd4, 8'h10);
        repeat (2) @(negedge clk);
        chk("irq_tx_set", irq, 1'b1);
        wr(3'd4, 8'h00);
        repeat (2) @(negedge clk);
        chk("irq_tx_clr", irq, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised next-generation UART with a Wishbone-style 8-bit register interface.
- Full TX and RX paths, each with its own FIFO.
- Runtime-selectable parity and stop-bit count, sticky error flags, and an interrupt output.
- Sits on the SoC peripheral bus and drives the board serial pins.

Parameters:
- DATA_BITS, 8, character width (5..8); register data above DATA_BITS reads 0 and is ignored on write.
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, minimum 2.
- OVERSAMPLE, 16, oversample ticks per bit; even, minimum 8.
- DIV_WIDTH, 16, width of the baud divider register (9..16).
- DEFAULT_DIV, 38, divider reset value; tick period is DIV+1 clks, so 12 MHz/39/16 = 19231 baud.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_bit  out  1  serial output, idle high
- rx_bit  in  1  serial input, asynchronous
- wb_addr  in  3  register address
- wb_data_in  in  8  write data
- wb_data_out  out  8  read data, registered
- wb_we  in  1  1 = write, 0 = read
- wb_stb  in  1  access strobe
- wb_ack  out  1  one-cycle acknowledge
- irq  out  1  level interrupt

Behaviour:
- Interface: clock clk; reset is synchronous, active-high.
- Reset values: tx_bit=1, wb_ack=0, wb_data_out=0, irq=0. Both FIFOs empty, DIV=DEFAULT_DIV, CTRL=0, error flags 0, both FSMs IDLE.
- Reset mid-frame aborts the frame; tx_bit returns to 1 on the next edge.
- Register map:
  - 0 TXDATA (W): push to TX FIFO; write ignored if the FIFO is full.
  - 1 RXDATA (R): pop RX FIFO; reads 0 and leaves the FIFO unchanged when empty.
  - 2 DIV_LO (R/W); 3 DIV_HI (R/W, bits above DIV_WIDTH-1 read 0).
  - 4 CTRL (R/W): b0 parity_en, b1 parity_odd, b2 two_stop, b3 ie_rx, b4 ie_tx.
  - 5 STATUS (R): b0 tx_full, b1 tx_empty, b2 rx_full, b3 rx_empty, b4 overrun, b5 frame_err, b6 parity_err, b7 tx_busy. Reading STATUS clears b4..b6 after their value is captured.
  - 6..7 read 0; writes ignored.
- Bus handshake:
  - An access is accepted when wb_stb=1 and wb_ack=0 at a clock edge. wb_ack=1 and wb_data_out are valid the following cycle; wb_ack drops the cycle after.
  - The next access can be accepted 2 cycles after the previous one was accepted.
  - A FIFO push or pop happens exactly once per accepted access, regardless of how long stb is held.
- Tick generator: counter runs 0..DIV and emits a 1-cycle tick when it wraps.
  - Writing DIV_LO or DIV_HI resets the counter to 0.
  - DIV=0 gives a tick every clk.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if parity_en) -> STOP -> IDLE.
  - Each state lasts OVERSAMPLE ticks.
  - IDLE pops the FIFO when it is non-empty; START begins on the next tick boundary.
  - Data is sent LSB first.
  - Parity bit = XOR of data bits, inverted when parity_odd.
  - STOP lasts 2*OVERSAMPLE ticks when two_stop=1.
  - tx_busy=1 outside IDLE.
  - A CTRL change takes effect at the next START.
- RX path: rx_bit passes through a 2-flop synchroniser (initialised to 1).
- RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE waits for a synchronised 0, then counts OVERSAMPLE/2 ticks. If the line is 1 at that point, it is treated as a glitch and the FSM returns to IDLE with no push.
  - Otherwise every later bit is sampled after OVERSAMPLE ticks (mid-bit).
  - Only the first stop bit is checked. If it is 0, frame_err is set, the byte is still pushed, and the FSM returns to IDLE only once the line is 1.
  - A parity mismatch sets parity_err; the byte is still pushed.
  - A push into a full RX FIFO drops the byte and sets overrun.
- FIFOs: synchronous with registered pointers; count width is log2(FIFO_DEPTH)+1.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - A pop on an empty FIFO is ignored, as is a push on a full FIFO.
- irq = (ie_rx & !rx_empty) | (ie_tx & tx_empty & !tx_busy), registered (1-cycle lag).

Test Plan:
- Reset, then read STATUS -> 0x0A; tx_bit=1; DIV reads 38/0; irq=0.
- Write DIV_LO=3, DIV_HI=0, CTRL=0; write TXDATA=0xA5.
  - tx_bit shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 64 clks wide.
  - STATUS b7 is 1 during the frame and 0 afterwards.
- Loop tx_bit to rx_bit with CTRL=0x03 (odd parity); send 0x00, 0xFF, 0x3C.
  - RXDATA returns the same bytes in order; parity_err stays 0 and the line carries parity bits 1, 1, 1.
- Drive rx_bit with a 0x55 frame whose stop bit is 0 -> frame_err=1 and 0x55 is readable. A second STATUS read shows frame_err=0.
  - Repeat with a corrupted parity bit -> parity_err=1.
- Send FIFO_DEPTH+1 bytes to RX without reading -> rx_full=1, overrun=1, and the first 16 bytes read back intact.
  - Write 17 TX bytes while the TX FIFO is full -> the 17th is never transmitted.
- Assert reset mid TX frame -> tx_bit=1 next cycle and STATUS=0x0A.
  - Apply a 2-tick rx_bit low glitch -> no RX push.
  - Set CTRL=0x08, then receive a byte -> irq=1; reading RXDATA -> irq=0.
